nic: RTL and testbench
======================

Name: nic

Overview:
- Per-node network interface controller. Sits directly downstream of each processor node's NIC port (addr_nic, din_to_nic, dout_from_nic, nicEn, nicWrEn) and upstream of the router's local port.
- Provides one 64-bit input channel buffer and one 64-bit output channel buffer, each with a full flag.
- The processor sees 4 registers; the router side uses a send/ready handshake gated by virtual-channel polarity.

Parameters:
- DATA_W, 64, packet/data width (bit 0 = MSB, big-endian ordering throughout).
- VC_BIT, 0, packet bit index holding the virtual-channel ID.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  [0:1]  register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status.
- d_in  in  [0:63]  processor write data.
- d_out  out  [0:63]  processor read data, registered.
- nicEn  in  1  access enable.
- nicWrEn  in  1  1 = write, 0 = read; meaningful only when nicEn=1.
- net_si  in  1  router presents a packet to NIC.
- net_ri  out  1  NIC can accept a packet.
- net_di  in  [0:63]  packet from router.
- net_so  out  1  NIC presents a packet to router.
- net_ro  in  1  router can accept a packet.
- net_do  out  [0:63]  packet to router.
- net_polarity  in  1  router's current VC phase.

Behaviour:
- Reset: in_full=0, out_full=0, both buffers=0, d_out=0. net_so=0 and net_ri=1 in the cycle after reset. Reset has priority over every other event, including mid-handshake.
- net_ri = ~in_full (combinational).
- Router ingress: at an edge with net_si=1 and net_ri=1, in_buf<=net_di and in_full<=1.
- Processor read (nicEn=1, nicWrEn=0) updates d_out at that edge; data is visible 1 cycle later. d_out holds its value when there is no read.
  - 00: d_out<=in_buf; in_full<=0 at the same edge. Reading while in_full=0 returns the stale in_buf and leaves in_full unchanged.
  - 01: d_out<={63'b0, in_full}.
  - 10: d_out<=out_buf.
  - 11: d_out<={63'b0, out_full}.
- Processor write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0 at the edge: out_buf<=d_in, out_full<=1.
  - addr 10 with out_full=1: write silently dropped; buffer unchanged.
  - Writes to 00, 01, 11 are ignored.
- Egress: net_so = out_full & net_ro & (out_buf[VC_BIT]==net_polarity) (combinational); net_do = out_buf at all times. At an edge with net_so=1, out_full<=0.
- Simultaneous events:
  - Egress while a processor write to 10 occurs in the same cycle: the write is dropped, because out_full was 1 at that edge. The processor must poll 11 first.
  - Processor read of 00 while net_si=1 and in_full=1: no ingress that cycle (net_ri=0); the router retries and is accepted the next cycle.
  - Ingress and a status-01 read in the same cycle: d_out reflects the pre-edge in_full.
- Polarity mismatch: out_full stays 1 and net_so stays 0 until net_polarity matches; no timeout.

Optional Feature:
- Macro NIC_STATS_EN.
- Defined: two 32-bit wrapping counters, tx_cnt (increments on each egress edge) and rx_cnt (increments on each ingress edge); both reset to 0.
  - Read of 11 returns {tx_cnt, 31'b0, out_full}.
  - Read of 01 returns {rx_cnt, 31'b0, in_full}.
  - 0xFFFFFFFF wraps to 0.
- Undefined: no counters; status upper bits read 0 as specified above.

Test Plan:
- Egress match: write 0x0123456789ABCDEF (bit0=0) to 10; read 11 returns 0x...01. With net_ro=1 and net_polarity=0, net_so pulses for 1 cycle with net_do=0x0123456789ABCDEF. Next read of 11 returns 0.
- Polarity hold: out_buf bit0=1, net_polarity=0 for 5 cycles -> net_so=0 throughout. Flip net_polarity to 1 -> net_so=1 for exactly one cycle.
- Ingress: net_si=1, net_di=0xDEADBEEF00000001 -> net_ri drops next cycle. Second packet held off while net_ri=0. Read 00 returns 0xDEADBEEF00000001 one cycle later and net_ri=1; the held packet is then accepted.
- Full drop: two consecutive writes to 10 (0xA…, then 0xB…) with net_ro=0 -> out_buf keeps the 0xA… value; read 10 confirms it.
- Reset mid-operation: in_full=1 and out_full=1 with net_ro=1 asserted in the reset cycle -> no egress. After reset, status reads return 0, net_ri=1, net_so=0.
- NIC_STATS_EN: 3 egress and 2 ingress transfers -> read 11 upper 32 bits = 3, read 01 upper 32 bits = 2. Preload rx_cnt to 0xFFFFFFFF via forced state, perform one ingress -> upper 32 bits read 0.

Source files
------------

// File: rtl/nic_if.sv
// Processor-side register port and router-side local port of one NIC, bundled.
// The slave modport is the NIC itself; master is the processor/router side.
interface nic_if #(
    parameter int DATA_W = 64
);
    logic [0:1]        addr;
    logic [0:DATA_W-1] d_in;
    logic [0:DATA_W-1] d_out;
    logic              nicEn;
    logic              nicWrEn;
    logic              net_si;
    logic              net_ri;
    logic [0:DATA_W-1] net_di;
    logic              net_so;
    logic              net_ro;
    logic [0:DATA_W-1] net_do;
    logic              net_polarity;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn,
        input  net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn,
        output net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic.sv
// Network interface controller: one input and one output packet buffer between a
// processor register port and a router local port. Optional traffic counters via NIC_STATS_EN.
module nic #(
    parameter int DATA_W = 64,
    parameter int VC_BIT = 0
) (
    input  logic  clk,
    input  logic  reset,
    nic_if.slave  bus
);

    logic [0:DATA_W-1] in_buf_q,  in_buf_d;
    logic [0:DATA_W-1] out_buf_q, out_buf_d;
    logic [0:DATA_W-1] d_out_q,   d_out_d;
    logic              in_full_q,  in_full_d;
    logic              out_full_q, out_full_d;

    logic rd_s;
    logic wr_s;
    logic ingress_s;
    logic egress_s;
    logic vc_match_s;

`ifdef NIC_STATS_EN
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;

    // Status word: counter in the upper 32 bits, full flag in the last bit.
    function automatic logic [0:DATA_W-1] status_word(input logic [31:0] cnt, input logic flag);
        logic [0:DATA_W-1] w;
        w           = '0;
        w[0:31]     = cnt;
        w[DATA_W-1] = flag;
        return w;
    endfunction
`else
    // Status word: full flag in the last bit, everything else zero.
    function automatic logic [0:DATA_W-1] status_word(input logic flag);
        logic [0:DATA_W-1] w;
        w           = '0;
        w[DATA_W-1] = flag;
        return w;
    endfunction
`endif

    // Access decode and the two router handshakes.
    always_comb begin
        rd_s       = bus.nicEn & ~bus.nicWrEn;
        wr_s       = bus.nicEn &  bus.nicWrEn;
        ingress_s  = bus.net_si & ~in_full_q;
        vc_match_s = (out_buf_q[VC_BIT] == bus.net_polarity);
        egress_s   = out_full_q & bus.net_ro & vc_match_s;
    end

    // Input buffer: ingress only fills an empty buffer, so it never races a drain.
    always_comb begin
        in_buf_d  = in_buf_q;
        in_full_d = in_full_q;
        if (ingress_s) begin
            in_buf_d  = bus.net_di;
            in_full_d = 1'b1;
        end else if (rd_s && (bus.addr == 2'b00)) begin
            in_full_d = 1'b0;
        end else begin
            in_full_d = in_full_q;
        end
    end

    // Output buffer: a write while full (including the egress cycle) is dropped.
    always_comb begin
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        if (egress_s) begin
            out_full_d = 1'b0;
        end else if (wr_s && (bus.addr == 2'b10) && !out_full_q) begin
            out_buf_d  = bus.d_in;
            out_full_d = 1'b1;
        end else begin
            out_full_d = out_full_q;
        end
    end

    // Read data mux; status reads see pre-edge flags and counters.
    always_comb begin
        d_out_d = d_out_q;
        if (rd_s) begin
            case (bus.addr)
                2'b00: d_out_d = in_buf_q;
`ifdef NIC_STATS_EN
                2'b01: d_out_d = status_word(rx_cnt_q, in_full_q);
`else
                2'b01: d_out_d = status_word(in_full_q);
`endif
                2'b10: d_out_d = out_buf_q;
`ifdef NIC_STATS_EN
                2'b11: d_out_d = status_word(tx_cnt_q, out_full_q);
`else
                2'b11: d_out_d = status_word(out_full_q);
`endif
                default: d_out_d = d_out_q;
            endcase
        end else begin
            d_out_d = d_out_q;
        end
    end

`ifdef NIC_STATS_EN
    // Traffic counters wrap naturally at 32 bits.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (egress_s) begin
            tx_cnt_d = tx_cnt_q + 32'd1;
        end else begin
            tx_cnt_d = tx_cnt_q;
        end
        if (ingress_s) begin
            rx_cnt_d = rx_cnt_q + 32'd1;
        end else begin
            rx_cnt_d = rx_cnt_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt_q <= 32'd0;
            rx_cnt_q <= 32'd0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end
`endif

    // Buffer, flag and read-data state; reset overrides any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf_q   <= '0;
            out_buf_q  <= '0;
            d_out_q    <= '0;
            in_full_q  <= 1'b0;
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            out_buf_q  <= out_buf_d;
            d_out_q    <= d_out_d;
            in_full_q  <= in_full_d;
            out_full_q <= out_full_d;
        end
    end

    assign bus.d_out  = d_out_q;
    assign bus.net_ri = ~in_full_q;
    assign bus.net_so = egress_s;
    assign bus.net_do = out_buf_q;

endmodule

// File: tb/tb_nic.sv
// Self-checking bench for nic: read expectations go through a scoreboard queue,
// handshake outputs are checked inline per scenario.
module tb_nic;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nic_if #(.DATA_W(64)) bus ();
    nic #(.DATA_W(64), .VC_BIT(0)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

`ifdef NIC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [0:63] sb[$];
    logic [0:63] exp_v;
    logic [31:0] tx_m;
    logic [31:0] rx_m;

    function automatic logic [0:63] exp_stat(input logic [31:0] cnt, input logic flag);
        logic [0:63] w;
        w       = '0;
        w[63]   = flag;
        w[0:31] = STATS ? cnt : 32'h0;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rd(input logic [0:1] a, input logic [0:63] e);
        bus.addr    = a;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b0;
        sb.push_back(e);
        step();
        bus.nicEn = 1'b0;
    endtask

    task automatic wr(input logic [0:1] a, input logic [0:63] d);
        bus.addr    = a;
        bus.d_in    = d;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b1;
        step();
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        tx_m  = 32'd0;
        rx_m  = 32'd0;
        settle();
        total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL reset_ri got=%b want=1", bus.net_ri); end
        total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL reset_so got=%b want=0", bus.net_so); end
        total++; if (bus.d_out !== 64'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", bus.d_out); end
        rd(2'b01, exp_stat(rx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL reset_st01 got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b11, exp_stat(tx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL reset_st11 got=%h want=%h", bus.d_out, exp_v); end
    endtask

    task automatic test_egress();
        wr(2'b10, 64'h0123_4567_89AB_CDEF);
        rd(2'b11, exp_stat(tx_m, 1'b1));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL egr_st_full got=%h want=%h", bus.d_out, exp_v); end
        bus.net_ro = 1'b1;
        settle();
        total++; if (bus.net_so !== 1'b1) begin bad++; $display("FAIL egr_so got=%b want=1", bus.net_so); end
        total++; if (bus.net_do !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL egr_do got=%h want=0123456789abcdef", bus.net_do); end
        step();
        tx_m++;
        total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL egr_so_pulse got=%b want=0", bus.net_so); end
        bus.net_ro = 1'b0;
        rd(2'b11, exp_stat(tx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL egr_st_empty got=%h want=%h", bus.d_out, exp_v); end
    endtask

    task automatic test_polarity();
        wr(2'b10, 64'h8000_0000_0000_0055);
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL pol_hold%0d got=%b want=0", i, bus.net_so); end
            step();
        end
        bus.net_polarity = 1'b1;
        settle();
        total++; if (bus.net_so !== 1'b1) begin bad++; $display("FAIL pol_match got=%b want=1", bus.net_so); end
        step();
        tx_m++;
        total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL pol_pulse got=%b want=0", bus.net_so); end
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
    endtask

    task automatic test_ingress();
        bus.net_di = 64'hDEAD_BEEF_0000_0001;
        bus.net_si = 1'b1;
        settle();
        total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL ing_ri_idle got=%b want=1", bus.net_ri); end
        step();
        rx_m++;
        total++; if (bus.net_ri !== 1'b0) begin bad++; $display("FAIL ing_ri_full got=%b want=0", bus.net_ri); end
        bus.net_di = 64'h1111_2222_3333_4444;
        step();
        total++; if (bus.net_ri !== 1'b0) begin bad++; $display("FAIL ing_held got=%b want=0", bus.net_ri); end
        rd(2'b00, 64'hDEAD_BEEF_0000_0001);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL ing_rd0 got=%h want=%h", bus.d_out, exp_v); end
        total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL ing_ri_drained got=%b want=1", bus.net_ri); end
        step();
        rx_m++;
        bus.net_si = 1'b0;
        total++; if (bus.net_ri !== 1'b0) begin bad++; $display("FAIL ing_retry got=%b want=0", bus.net_ri); end
        rd(2'b00, 64'h1111_2222_3333_4444);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL ing_rd1 got=%h want=%h", bus.d_out, exp_v); end
        // Status read racing an ingress reports the pre-edge state.
        bus.net_di = 64'h2222_3333_4444_5555;
        bus.net_si = 1'b1;
        rd(2'b01, exp_stat(rx_m, 1'b0));
        rx_m++;
        bus.net_si = 1'b0;
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL ing_st_race got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b01, exp_stat(rx_m, 1'b1));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL ing_st_full got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b00, 64'h2222_3333_4444_5555);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL ing_rd2 got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b00, 64'h2222_3333_4444_5555);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL ing_stale got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b01, exp_stat(rx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL ing_st_empty got=%h want=%h", bus.d_out, exp_v); end
    endtask

    task automatic test_full_drop();
        wr(2'b10, 64'hAAAA_AAAA_AAAA_AAAA);
        wr(2'b10, 64'hBBBB_BBBB_BBBB_BBBB);
        rd(2'b10, 64'hAAAA_AAAA_AAAA_AAAA);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL drop_rd got=%h want=%h", bus.d_out, exp_v); end
        total++; if (bus.net_do !== 64'hAAAA_AAAA_AAAA_AAAA) begin bad++; $display("FAIL drop_do got=%h want=aaaaaaaaaaaaaaaa", bus.net_do); end
        // Write landing on the egress edge is dropped.
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        wr(2'b10, 64'hCCCC_CCCC_CCCC_CCCC);
        tx_m++;
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
        rd(2'b11, exp_stat(tx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL drop_race_st got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b10, 64'hAAAA_AAAA_AAAA_AAAA);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL drop_race_buf got=%h want=%h", bus.d_out, exp_v); end
    endtask

    task automatic test_reset_mid();
        bus.net_di = 64'h5555_5555_5555_5555;
        bus.net_si = 1'b1;
        step();
        bus.net_si = 1'b0;
        wr(2'b10, 64'h0000_0000_0000_0077);
        bus.net_ro = 1'b1;
        settle();
        total++; if (bus.net_so !== 1'b1) begin bad++; $display("FAIL rstmid_pre_so got=%b want=1", bus.net_so); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tx_m  = 32'd0;
        rx_m  = 32'd0;
        settle();
        total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL rstmid_so got=%b want=0", bus.net_so); end
        total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL rstmid_ri got=%b want=1", bus.net_ri); end
        bus.net_ro = 1'b0;
        rd(2'b01, exp_stat(rx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL rstmid_st01 got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b11, exp_stat(tx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL rstmid_st11 got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b10, 64'h0);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL rstmid_buf got=%h want=%h", bus.d_out, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [0:63] d;
        for (int i = 0; i < 3; i++) begin
            d = {32'h0F00_0000 + 32'(i), 32'h1234_5678};
            wr(2'b10, d);
            bus.net_ro = 1'b1;
            settle();
            total++; if (bus.net_so !== 1'b1 || bus.net_do !== d) begin bad++; $display("FAIL b2b_tx%0d got=%b/%h want=1/%h", i, bus.net_so, bus.net_do, d); end
            step();
            tx_m++;
            bus.net_ro = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            d = {32'hC0DE_0000 + 32'(j), 32'h8765_4321};
            bus.net_di = d;
            bus.net_si = 1'b1;
            step();
            rx_m++;
            bus.net_si = 1'b0;
            rd(2'b00, d);
            exp_v = sb.pop_front(); total++;
            if (bus.d_out !== exp_v) begin bad++; $display("FAIL b2b_rx%0d got=%h want=%h", j, bus.d_out, exp_v); end
        end
        rd(2'b11, exp_stat(tx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL b2b_st11 got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b01, exp_stat(rx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL b2b_st01 got=%h want=%h", bus.d_out, exp_v); end
    endtask

`ifdef NIC_STATS_EN
    task automatic test_stats_wrap();
        force dut.rx_cnt_q = 32'hFFFF_FFFF;
        settle();
        release dut.rx_cnt_q;
        bus.net_di = 64'h7777_0000_0000_7777;
        bus.net_si = 1'b1;
        step();
        rx_m       = 32'd0;
        bus.net_si = 1'b0;
        rd(2'b00, 64'h7777_0000_0000_7777);
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL wrap_rd got=%h want=%h", bus.d_out, exp_v); end
        rd(2'b01, exp_stat(rx_m, 1'b0));
        exp_v = sb.pop_front(); total++;
        if (bus.d_out !== exp_v) begin bad++; $display("FAIL wrap_st01 got=%h want=%h", bus.d_out, exp_v); end
    endtask
`endif

    initial begin
        reset            = 1'b1;
        bus.addr         = 2'b00;
        bus.d_in         = 64'h0;
        bus.nicEn        = 1'b0;
        bus.nicWrEn      = 1'b0;
        bus.net_si       = 1'b0;
        bus.net_di       = 64'h0;
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
        tx_m             = 32'd0;
        rx_m             = 32'd0;
        test_reset();
        test_egress();
        test_polarity();
        test_ingress();
        test_full_drop();
        test_reset_mid();
        test_back_to_back();
`ifdef NIC_STATS_EN
        test_stats_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
